// File: rtl/alu_seq_unit.sv
// Handshaked W-bit ALU execution unit: ADD, LSH, RSH, XOR, AND, SUB, CLR with flags and tag passthrough.
// Shifts iterate one bit per cycle; define ALU_BARREL_EN for single-cycle barrel shifts.
module alu_seq_unit #(
  parameter int W     = 8,
  parameter int TAG_W = 2,
  localparam int SHW  = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_LSH = 3'b001;
  localparam logic [2:0] OP_RSH = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_CLR = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   work_q;
  logic [SHW-1:0] cnt_q;
  logic           left_q;
  logic           accept;
  logic           is_shift;
  logic [SHW-1:0] k_in;
  logic [W:0]     eval_res;
  logic [W:0]     step_res;
  logic           last_step;

  // Returns {carry, result}; the extra bit catches the last bit shifted out,
  // and shifts of k > W naturally leave both carry and result at zero.
  function automatic logic [W:0] shift_by(input logic left, input logic [W-1:0] a,
                                          input logic [SHW-1:0] k);
    logic [W:0] wide;
    if (left) begin
      wide = {1'b0, a} << k;
      return wide;
    end
    wide = {a, 1'b0} >> k;
    return {wide[0], wide[W:1]};
  endfunction

  // Single-cycle evaluation, {carry, result}; iterative shifts only use the k == 0 case here.
  function automatic logic [W:0] alu_eval(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0] r;
    r = '0;
    case (op)
      OP_ADD: r = {1'b0, a} + {1'b0, b};
      OP_SUB: r = {1'b0, a} - {1'b0, b};
`ifdef ALU_BARREL_EN
      OP_LSH, OP_RSH: r = shift_by(op == OP_LSH, a, b[SHW-1:0]);
`else
      OP_LSH, OP_RSH: r = {1'b0, a};
`endif
      OP_XOR: r = {1'b0, a ^ b};
      OP_AND: r = {1'b0, a & b};
      OP_CLR: r = '0;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept    = in_valid && (state_q == IDLE);
  assign is_shift  = (in_op == OP_LSH) || (in_op == OP_RSH);
  assign k_in      = in_b[SHW-1:0];
  assign eval_res  = alu_eval(in_op, in_a, in_b);
  assign step_res  = shift_by(left_q, work_q, SHW'(1));
  assign last_step = (state_q == SHIFT) && (cnt_q == SHW'(1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_BARREL_EN
          state_d = DONE;
`else
          state_d = (is_shift && (k_in != '0)) ? SHIFT : DONE;
`endif
        end
      end
      SHIFT:   if (cnt_q == SHW'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Working shift register and counter carry no reset; they are only read in SHIFT.
  always_ff @(posedge clk) begin
    if (accept) begin
      work_q <= in_a;
      cnt_q  <= k_in;
      left_q <= (in_op == OP_LSH);
    end else if (state_q == SHIFT) begin
      work_q <= step_res[W-1:0];
      cnt_q  <= cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
      out_err    <= 1'b0;
      out_tag    <= '0;
    end else if (accept) begin
      out_result <= eval_res[W-1:0];
      out_zero   <= (eval_res[W-1:0] == '0);
      out_carry  <= eval_res[W];
      out_err    <= (in_op == OP_ILL);
      out_tag    <= in_tag;
    end else if (last_step) begin
      out_result <= step_res[W-1:0];
      out_zero   <= (step_res[W-1:0] == '0);
      out_carry  <= step_res[W];
      out_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed testbench for alu_seq_unit (W=8, TAG_W=2) with hand-computed expectations.
module tb_alu_seq_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_zero;
  logic       out_carry;
  logic       out_err;
  logic [1:0] out_tag;

  int checks = 0;
  int errors = 0;

  alu_seq_unit #(.W(8), .TAG_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_carry(out_carry),
    .out_err(out_err), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for a single edge, then count cycles until out_valid (bounded).
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] tag, output int lat);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 8'h00; in_b = 8'h00; in_op = 3'b000; in_tag = 2'd0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 8'h00 || out_zero !== 1'b0 ||
        out_carry !== 1'b0 || out_err !== 1'b0 || out_tag !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b result=%h zero=%b carry=%b err=%b tag=%0d, expected all 0",
               out_valid, out_result, out_zero, out_carry, out_err, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add();
    int lat;
    issue(3'b000, 8'hF0, 8'h20, 2'd2, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL add_latency: got %0d expected 1", lat);
    end
    checks++;
    if (out_result !== 8'h10 || out_carry !== 1'b1 || out_zero !== 1'b0 ||
        out_err !== 1'b0 || out_tag !== 2'd2) begin
      errors++;
      $display("FAIL add_result: result=%h carry=%b zero=%b err=%b tag=%0d, expected 10 1 0 0 2",
               out_result, out_carry, out_zero, out_err, out_tag);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_valid_drop: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_sub();
    int lat;
    issue(3'b101, 8'h05, 8'h05, 2'd1, lat);
    checks++;
    if (out_result !== 8'h00 || out_zero !== 1'b1 || out_carry !== 1'b0 || out_tag !== 2'd1) begin
      errors++;
      $display("FAIL sub_equal: result=%h zero=%b carry=%b tag=%0d, expected 00 1 0 1",
               out_result, out_zero, out_carry, out_tag);
    end
    consume();
    issue(3'b101, 8'h03, 8'h05, 2'd3, lat);
    checks++;
    if (out_result !== 8'hFE || out_carry !== 1'b1 || out_zero !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL sub_borrow: result=%h carry=%b zero=%b lat=%0d, expected FE 1 0 1",
               out_result, out_carry, out_zero, lat);
    end
    consume();
  endtask

  task automatic test_shift();
    int lat;
    int exp3;
    int exp1;
`ifdef ALU_BARREL_EN
    exp3 = 1; exp1 = 1;
`else
    exp3 = 4; exp1 = 2;
`endif
    issue(3'b001, 8'h81, 8'h03, 2'd0, lat);
    checks++;
    if (lat !== exp3) begin
      errors++;
      $display("FAIL lsh3_latency: got %0d expected %0d", lat, exp3);
    end
    checks++;
    if (out_result !== 8'h08 || out_carry !== 1'b0 || out_zero !== 1'b0) begin
      errors++;
      $display("FAIL lsh3_result: result=%h carry=%b zero=%b, expected 08 0 0",
               out_result, out_carry, out_zero);
    end
    consume();
    issue(3'b010, 8'h81, 8'h01, 2'd1, lat);
    checks++;
    if (lat !== exp1) begin
      errors++;
      $display("FAIL rsh1_latency: got %0d expected %0d", lat, exp1);
    end
    checks++;
    if (out_result !== 8'h40 || out_carry !== 1'b1 || out_tag !== 2'd1) begin
      errors++;
      $display("FAIL rsh1_result: result=%h carry=%b tag=%0d, expected 40 1 1",
               out_result, out_carry, out_tag);
    end
    consume();
    issue(3'b001, 8'h5A, 8'h00, 2'd2, lat);
    checks++;
    if (lat !== 1 || out_result !== 8'h5A || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL lsh0: lat=%0d result=%h carry=%b, expected 1 5A 0", lat, out_result, out_carry);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(3'b011, 8'hAA, 8'h0F, 2'd3, lat);
    checks++;
    if (out_result !== 8'hA5 || out_carry !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL xor_result: result=%h carry=%b lat=%0d, expected A5 0 1", out_result, out_carry, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'b000; in_a = 8'h01; in_b = 8'h01; in_tag = 2'd0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 8'hA5 || out_tag !== 2'd3) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b in_ready=%b result=%h tag=%0d, expected 1 0 A5 3",
                 i, out_valid, in_ready, out_result, out_tag);
      end
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_clr_illegal();
    int lat;
    issue(3'b111, 8'hFF, 8'h12, 2'd1, lat);
    checks++;
    if (lat !== 1 || out_result !== 8'h00 || out_err !== 1'b1 || out_zero !== 1'b1 || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL illegal: lat=%0d result=%h err=%b zero=%b carry=%b, expected 1 00 1 1 0",
               lat, out_result, out_err, out_zero, out_carry);
    end
    consume();
    issue(3'b110, 8'hFF, 8'hFF, 2'd2, lat);
    checks++;
    if (out_result !== 8'h00 || out_err !== 1'b0 || out_zero !== 1'b1 || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL clr: result=%h err=%b zero=%b carry=%b, expected 00 0 1 0",
               out_result, out_err, out_zero, out_carry);
    end
    consume();
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    int seen;
    @(negedge clk);
    in_op = 3'b001; in_a = 8'h0F; in_b = 8'h05; in_tag = 2'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 8'h00 || out_tag !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b in_ready=%b result=%h tag=%0d, expected 0 1 00 0",
               out_valid, in_ready, out_result, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    checks++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL aborted_op: valid cycles=%0d in_ready=%b, expected 0 1", seen, in_ready);
    end
    issue(3'b100, 8'hF0, 8'h3C, 2'd1, lat);
    checks++;
    if (lat !== 1 || out_result !== 8'h30 || out_carry !== 1'b0 || out_tag !== 2'd1) begin
      errors++;
      $display("FAIL and_after_reset: lat=%0d result=%h carry=%b tag=%0d, expected 1 30 0 1",
               lat, out_result, out_carry, out_tag);
    end
    consume();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_a = 8'h00; in_b = 8'h00;
    in_tag = 2'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_add();
    test_sub();
    test_shift();
    test_backpressure();
    test_clr_illegal();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
